// File: rtl/value_sync_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : value_sync_filter_pkg
//  Description : Shared constants and helpers for the value_sync_filter block.
//  Revision    : 1.0 - initial release
// ============================================================================
package value_sync_filter_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Stability counter width: max(1, clog2(n)); n = 0 or 1 still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/value_sync_filter_chan.sv
`default_nettype none
// ============================================================================
//  Module      : value_sync_filter_chan
//  Description : One channel: flop-chain synchroniser followed by a stability
//                qualifier that only publishes words held long enough.
//  Revision    : 1.0 - initial release
// ============================================================================
module value_sync_filter_chan
    import value_sync_filter_pkg::*;
#(
    parameter int BITS          = 32,
    parameter int SYNC_STAGES   = 3,
    parameter int STABLE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] value_async,
    output logic [BITS-1:0] value_sync,
    output logic            changed,
    output logic            changed_nxt
);

    localparam int c_cnt_w = clog2_min1(STABLE_CYCLES);

    (* ASYNC_REG = "TRUE" *) logic [BITS-1:0] r_sync_q [SYNC_STAGES];
    logic [BITS-1:0] w_sync_d [SYNC_STAGES];
    logic [BITS-1:0] w_s;

    logic [BITS-1:0] r_value_q, w_value_d;
    logic            r_changed_q, w_changed_d;

    always_comb begin
        w_sync_d[0] = value_async;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            w_sync_d[i] = r_sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync_q[i] <= w_sync_d[i];
            end
        end
    end

    assign w_s = r_sync_q[SYNC_STAGES-1];

    if (STABLE_CYCLES > 0) begin : g_filter
        localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_CYCLES - 1);

        logic [BITS-1:0]    r_cand_q, w_cand_d;
        logic [c_cnt_w-1:0] r_cnt_q,  w_cnt_d;

        // Any difference restarts qualification; the count saturates so a
        // held candidate stays ready to commit until it differs from the output.
        always_comb begin
            w_cand_d    = r_cand_q;
            w_cnt_d     = r_cnt_q;
            w_value_d   = r_value_q;
            w_changed_d = 1'b0;
            if (w_s != r_cand_q) begin
                w_cand_d = w_s;
                w_cnt_d  = '0;
            end else if (r_cnt_q != c_cnt_last) begin
                w_cnt_d = r_cnt_q + c_cnt_w'(1);
            end else if (r_cand_q != r_value_q) begin
                w_value_d   = r_cand_q;
                w_changed_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cand_q <= '0;
                r_cnt_q  <= '0;
            end else begin
                r_cand_q <= w_cand_d;
                r_cnt_q  <= w_cnt_d;
            end
        end
    end else begin : g_bypass
        always_comb begin
            w_value_d   = w_s;
            w_changed_d = (w_s != r_value_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value_q   <= '0;
            r_changed_q <= 1'b0;
        end else begin
            r_value_q   <= w_value_d;
            r_changed_q <= w_changed_d;
        end
    end

    assign value_sync  = r_value_q;
    assign changed     = r_changed_q;
    assign changed_nxt = w_changed_d;

endmodule
`default_nettype wire

// File: rtl/value_sync_filter.sv
`default_nettype none
// ============================================================================
//  Module      : value_sync_filter
//  Description : Multi-channel, multi-bit synchroniser with stability
//                qualification; publishes only coherent, settled words.
//  Revision    : 1.0 - initial release
// ============================================================================
module value_sync_filter
    import value_sync_filter_pkg::*;
#(
    parameter int CHANNELS      = 1,
    parameter int BITS          = 32,
    parameter int SYNC_STAGES   = 3,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CHANNELS*BITS-1:0] value_async,
    output logic [CHANNELS*BITS-1:0] value_sync,
    output logic [CHANNELS-1:0]      changed,
    output logic                     any_changed
);

    logic [CHANNELS-1:0] w_changed_nxt;
    logic                w_any_d;
    logic                r_any_q;

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("value_sync_filter: SYNC_STAGES=%0d outside %0d..%0d",
               SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end
    if (STABLE_CYCLES < 0) begin : g_bad_stable
        $error("value_sync_filter: STABLE_CYCLES=%0d must be >= 0", STABLE_CYCLES);
    end
    if (CHANNELS < 1 || BITS < 1) begin : g_bad_shape
        $error("value_sync_filter: CHANNELS=%0d and BITS=%0d must be >= 1", CHANNELS, BITS);
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        value_sync_filter_chan #(
            .BITS          (BITS),
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .value_async (value_async[c*BITS +: BITS]),
            .value_sync  (value_sync[c*BITS +: BITS]),
            .changed     (changed[c]),
            .changed_nxt (w_changed_nxt[c])
        );
    end

    // Registered from the channels' next-state so it aligns with changed[].
    always_comb begin
        w_any_d = |w_changed_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any_q <= 1'b0;
        end else begin
            r_any_q <= w_any_d;
        end
    end

    assign any_changed = r_any_q;

endmodule
`default_nettype wire

// File: tb/tb_value_sync_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_value_sync_filter
//  Description : Self-checking bench for value_sync_filter against a
//                sample-window reference model; default and bypass configs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_value_sync_filter;

    localparam int W      = 32;
    localparam int A_CH   = 4;
    localparam int A_SYNC = 3;
    localparam int A_STAB = 4;
    localparam int B_SYNC = 2;
    localparam int B_STAB = 0;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic [A_CH*W-1:0]   va_a  = '0;
    logic [A_CH*W-1:0]   vs_a;
    logic [A_CH-1:0]     chg_a;
    logic                any_a;
    logic [W-1:0]        va_b  = '0;
    logic [W-1:0]        vs_b;
    logic                chg_b;
    logic                any_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    value_sync_filter #(
        .CHANNELS(A_CH), .BITS(W), .SYNC_STAGES(A_SYNC), .STABLE_CYCLES(A_STAB)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .value_async(va_a),
        .value_sync(vs_a), .changed(chg_a), .any_changed(any_a)
    );

    value_sync_filter #(
        .CHANNELS(1), .BITS(W), .SYNC_STAGES(B_SYNC), .STABLE_CYCLES(B_STAB)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .value_async(va_b),
        .value_sync(vs_b), .changed(chg_b), .any_changed(any_b)
    );

    // Reference: synced sample = input seen SYNC edges earlier; a word is
    // published once STABLE+1 consecutive synced samples agree and differ
    // from what is already published.
    logic [W-1:0] m_a   [2][4][8];
    logic [W-1:0] m_s   [2][4][8];
    logic [W-1:0] m_vs  [2][4];
    logic         m_chg [2][4];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++) begin
                for (int i = 0; i < 8; i++) begin
                    m_a[d][c][i] = '0;
                    m_s[d][c][i] = '0;
                end
                m_vs[d][c]  = '0;
                m_chg[d][c] = 1'b0;
            end
    endtask

    task automatic model_chan(input int d, input int c, input logic [W-1:0] x,
                              input int sync, input int stab);
        logic [W-1:0] s;
        bit           eq;
        s = m_a[d][c][sync-1];
        for (int i = 7; i > 0; i--) m_s[d][c][i] = m_s[d][c][i-1];
        m_s[d][c][0] = s;
        eq = 1'b1;
        for (int i = 1; i <= stab; i++) if (m_s[d][c][i] != s) eq = 1'b0;
        m_chg[d][c] = 1'b0;
        if (eq && s != m_vs[d][c]) begin
            m_vs[d][c]  = s;
            m_chg[d][c] = 1'b1;
        end
        for (int i = 7; i > 0; i--) m_a[d][c][i] = m_a[d][c][i-1];
        m_a[d][c][0] = x;
    endtask

    task automatic compare_all();
        logic [127:0]    ev;
        logic [A_CH-1:0] ec;
        ev = '0;
        ec = '0;
        for (int c = 0; c < A_CH; c++) begin
            ev[c*W +: W] = m_vs[0][c];
            ec[c]        = m_chg[0][c];
        end
        chk("vs_a",  vs_a, ev);
        chk("chg_a", 128'(chg_a), 128'(ec));
        chk("any_a", 128'(any_a), 128'(|ec));
        chk("vs_b",  128'(vs_b),  128'(m_vs[1][0]));
        chk("chg_b", 128'(chg_b), 128'(m_chg[1][0]));
        chk("any_b", 128'(any_b), 128'(m_chg[1][0]));
    endtask

    // Advance one edge; inputs change only at +1 after an edge, outputs checked there.
    task automatic tick();
        if (rst_n) begin
            for (int c = 0; c < A_CH; c++) model_chan(0, c, va_a[c*W +: W], A_SYNC, A_STAB);
            model_chan(1, 0, va_b, B_SYNC, B_STAB);
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic edges_to_chg_a(input int ch, output int e);
        e = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (chg_a[ch]) begin
                e = k;
                break;
            end
        end
    endtask

    int e;
    int pulses;
    int full;
    int part;
    int anys;
    int bad;
    int hold_a [4];
    int hold_b;

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_vs", vs_a, '0);
        rst_n = 1'b1;

        // Idle: zero input never publishes anything.
        pulses = 0;
        repeat (20) begin
            tick();
            if (chg_a != '0 || any_a) pulses++;
        end
        chk("idle_pulses", 128'(pulses), 128'(0));

        // Clean step on ch0.
        va_a[31:0] = 32'hDEADBEEF;
        edges_to_chg_a(0, e);
        chk("lat_default", 128'(e), 128'(A_SYNC + A_STAB + 1));
        chk("step_val", 128'(vs_a[31:0]), 128'(32'hDEADBEEF));
        tick();
        chk("chg_one_cycle", 128'(chg_a[0]), 128'(0));
        chk("others_held", 128'(vs_a[127:32]), 128'(0));

        va_a[31:0] = '0;
        repeat (15) tick();

        // Glitch shorter than the qualify window.
        pulses = 0;
        va_a[31:0] = 32'h1234;
        repeat (3) begin tick(); if (chg_a[0]) pulses++; end
        va_a[31:0] = '0;
        repeat (15) begin tick(); if (chg_a[0]) pulses++; end
        chk("glitch_pulses", 128'(pulses), 128'(0));

        // A commit needs STABLE_CYCLES+1 agreeing synced samples.
        pulses = 0;
        va_a[31:0] = 32'h1234;
        repeat (A_STAB + 1) begin tick(); if (chg_a[0]) pulses++; end
        va_a[31:0] = '0;
        repeat (4) begin tick(); if (chg_a[0]) pulses++; end
        chk("hold_commit", 128'(pulses), 128'(1));
        repeat (12) tick();

        // Skewed update: low half leads by two cycles.
        pulses = 0;
        bad    = 0;
        va_a[15:0] = 16'h5A5A;
        repeat (2) begin
            tick();
            if (chg_a[0]) pulses++;
            if (vs_a[31:0] != 32'h0 && vs_a[31:0] != 32'hA5A55A5A) bad++;
        end
        va_a[31:16] = 16'hA5A5;
        repeat (20) begin
            tick();
            if (chg_a[0]) pulses++;
            if (vs_a[31:0] != 32'h0 && vs_a[31:0] != 32'hA5A55A5A) bad++;
        end
        chk("skew_pulses", 128'(pulses), 128'(1));
        chk("skew_partial", 128'(bad), 128'(0));
        chk("skew_val", 128'(vs_a[31:0]), 128'(32'hA5A55A5A));

        // All channels stepped together.
        full = 0; part = 0; anys = 0;
        va_a = {32'h44440004, 32'h33330003, 32'h22220002, 32'h11110001};
        repeat (20) begin
            tick();
            if (chg_a == 4'hF) full++;
            else if (chg_a != 4'h0) part++;
            if (any_a) anys++;
        end
        chk("all_together", 128'(full), 128'(1));
        chk("all_partial", 128'(part), 128'(0));
        chk("all_any", 128'(anys), 128'(1));

        // Staggered steps give separate pulses.
        anys = 0; part = 0;
        va_a[63:32] = 32'h0BAD0001;
        repeat (6) begin tick(); if (any_a) anys++; if (chg_a[1] && chg_a[2]) part++; end
        va_a[95:64] = 32'h0BAD0002;
        repeat (19) begin tick(); if (any_a) anys++; if (chg_a[1] && chg_a[2]) part++; end
        chk("stagger_any", 128'(anys), 128'(2));
        chk("stagger_merge", 128'(part), 128'(0));

        // Bypass config.
        va_b = 32'hCAFEF00D;
        e = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (chg_b) begin e = k; break; end
        end
        chk("lat_bypass", 128'(e), 128'(B_SYNC + 1));
        chk("bypass_val", 128'(vs_b), 128'(32'hCAFEF00D));

        // Reset at edge 5 of a qualification; async clear, then full re-qualify.
        va_a[31:0] = 32'h11112222;
        repeat (5) tick();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_clr_vs", vs_a, '0);
        chk("async_clr_b", 128'(vs_b), 128'(0));
        compare_all();
        repeat (2) tick();
        rst_n = 1'b1;
        edges_to_chg_a(0, e);
        chk("lat_after_rst", 128'(e), 128'(A_SYNC + A_STAB + 1));
        chk("val_after_rst", 128'(vs_a[31:0]), 128'(32'h11112222));
        repeat (10) tick();

        // Randomised traffic with mixed hold lengths, returns and skew-like flips.
        for (int c = 0; c < 4; c++) hold_a[c] = 0;
        hold_b = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < A_CH; c++) begin
                if (hold_a[c] == 0) begin
                    case ($urandom_range(0, 3))
                        0, 1: va_a[c*W +: W] = $urandom;
                        2:    va_a[c*W +: W] = m_vs[0][c];
                        default: va_a[c*W +: W] = va_a[c*W +: W] ^ W'($urandom_range(1, 16'hFFFF));
                    endcase
                    hold_a[c] = $urandom_range(1, 9);
                end
                hold_a[c]--;
            end
            if (hold_b == 0) begin
                va_b   = ($urandom_range(0, 1) == 1) ? $urandom : vs_b;
                hold_b = $urandom_range(1, 4);
            end
            hold_b--;
            if (cyc == 300) begin
                #3;
                rst_n = 1'b0;
                model_reset();
                #1;
                compare_all();
                repeat (2) tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
